// File: rtl/snake_dir_pkg.sv
// Shared direction encodings and helpers for the snake direction controller.
package snake_dir_pkg;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'b00,
        DIR_LEFT  = 2'b01,
        DIR_UP    = 2'b10,
        DIR_DOWN  = 2'b11
    } dir_t;

    // Opposite directions differ only in bit 0.
    function automatic dir_t opposite(input dir_t d);
        return dir_t'(d ^ 2'b01);
    endfunction

    // Bit order {down, up, left, right}.
    function automatic logic [3:0] dir_onehot(input dir_t d);
        logic [3:0] oh;
        oh    = 4'b0000;
        oh[d] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/dir_fifo.sv
// Small circular FIFO exposing both head and most recently written entry (tail).
module dir_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 2,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  head,
    output logic [W-1:0]  tail,
    output logic [CW-1:0] count,
    output logic          full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] last_ptr;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign full     = (count_q == CW'(DEPTH));
    assign count    = count_q;
    assign last_ptr = (wr_ptr_q == '0) ? LAST_PTR : wr_ptr_q - 1'b1;
    assign head     = mem_q[rd_ptr_q];
    assign tail     = mem_q[last_ptr];

    // A pop in the same cycle frees the slot a push into a full queue needs.
    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && (!full || do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clr) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_pop)
                rd_ptr_d = ptr_inc(rd_ptr_q);
            if (do_push)
                wr_ptr_d = ptr_inc(wr_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr)
            mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/dir_queue_ctrl.sv
// Snake direction controller: edge-detected turns, validated against the latest
// pending direction, queued, and applied one per game step.
module dir_queue_ctrl
    import snake_dir_pkg::*;
#(
    parameter int QDEPTH   = 4,
    parameter int TICK_DIV = 4,
    localparam int CW      = $clog2(QDEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          set,
    input  logic [1:0]    load_dir,
    input  logic          right_btn,
    input  logic          left_btn,
    input  logic          up_btn,
    input  logic          down_btn,
    input  logic          pause,
    output logic          out_right,
    output logic          out_left,
    output logic          out_up,
    output logic          out_down,
    output logic          step,
    output logic [CW-1:0] q_count,
    output logic          q_full,
    output logic          drop
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic             active_q, active_d;
    dir_t             cur_dir_q, cur_dir_d;
    logic [3:0]       btn, btn_q, press;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             step_q, step_d;
    logic             drop_q, drop_d;

    dir_t             cand, ref_dir;
    logic             consider, reject, tick_wrap;
    logic             fifo_push, fifo_pop;
    logic [1:0]       fifo_head, fifo_tail;
    logic [CW-1:0]    fifo_count;
    logic             fifo_full;
    logic [3:0]       dir_oh;

    assign btn   = {down_btn, up_btn, left_btn, right_btn};
    assign press = btn & ~btn_q;

    always_comb begin
        cand = DIR_DOWN;
        if (press[0])      cand = DIR_RIGHT;
        else if (press[1]) cand = DIR_LEFT;
        else if (press[2]) cand = DIR_UP;
    end

    assign tick_wrap = active_q && !set && !pause && (cnt_q == CNT_LAST);
    assign fifo_pop  = tick_wrap && (fifo_count != '0);

    // Validate against the turn that will be in effect last, not the current one.
    assign ref_dir  = (fifo_count != '0) ? dir_t'(fifo_tail) : cur_dir_q;
    assign consider = active_q && !set && (press != 4'b0000);
    assign reject   = (cand == ref_dir) || (cand == opposite(ref_dir))
                   || (fifo_full && !fifo_pop);
    assign fifo_push = consider && !reject;

    always_comb begin
        active_d  = active_q;
        cur_dir_d = cur_dir_q;
        cnt_d     = cnt_q;
        step_d    = 1'b0;
        drop_d    = consider && reject;
        if (set) begin
            active_d  = 1'b1;
            cur_dir_d = dir_t'(load_dir);
            cnt_d     = '0;
        end else if (active_q && !pause) begin
            cnt_d  = tick_wrap ? '0 : cnt_q + 1'b1;
            step_d = tick_wrap;
            if (fifo_pop)
                cur_dir_d = dir_t'(fifo_head);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_q  <= 1'b0;
            cur_dir_q <= DIR_RIGHT;
            btn_q     <= 4'b0000;
            cnt_q     <= '0;
            step_q    <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            active_q  <= active_d;
            cur_dir_q <= cur_dir_d;
            btn_q     <= btn;
            cnt_q     <= cnt_d;
            step_q    <= step_d;
            drop_q    <= drop_d;
        end
    end

    dir_fifo #(
        .DEPTH (QDEPTH),
        .W     (2)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clr   (set),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (cand),
        .head  (fifo_head),
        .tail  (fifo_tail),
        .count (fifo_count),
        .full  (fifo_full)
    );

    assign dir_oh    = active_q ? dir_onehot(cur_dir_q) : 4'b0000;
    assign out_right = dir_oh[0];
    assign out_left  = dir_oh[1];
    assign out_up    = dir_oh[2];
    assign out_down  = dir_oh[3];
    assign step      = step_q;
    assign drop      = drop_q;
    assign q_count   = fifo_count;
    assign q_full    = fifo_full;

endmodule

// File: tb/tb_dir_queue_ctrl.sv
// Directed bench for dir_queue_ctrl (QDEPTH=4, TICK_DIV=4): vector table plus reset/step/flush sequences.
module tb_dir_queue_ctrl;

    logic       clk = 1'b0;
    logic       reset, set, pause;
    logic [1:0] load_dir;
    logic       right_btn, left_btn, up_btn, down_btn;
    logic       out_right, out_left, out_up, out_down;
    logic       step, q_full, drop;
    logic [2:0] q_count;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    dir_queue_ctrl #(
        .QDEPTH   (4),
        .TICK_DIV (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .set       (set),
        .load_dir  (load_dir),
        .right_btn (right_btn),
        .left_btn  (left_btn),
        .up_btn    (up_btn),
        .down_btn  (down_btn),
        .pause     (pause),
        .out_right (out_right),
        .out_left  (out_left),
        .out_up    (out_up),
        .out_down  (out_down),
        .step      (step),
        .q_count   (q_count),
        .q_full    (q_full),
        .drop      (drop)
    );

    // btn and e_dir bit order: {down, up, left, right}
    typedef struct {
        logic       set;
        logic [1:0] ld;
        logic [3:0] btn;
        logic       pause;
        logic [3:0] e_dir;
        logic       e_step;
        logic [2:0] e_qc;
        logic       e_full;
        logic       e_drop;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic s, input logic [1:0] ld, input logic [3:0] b, input logic p,
                       input logic [3:0] d, input logic st, input logic [2:0] qc,
                       input logic f, input logic dr);
        vec_t v;
        v.set = s; v.ld = ld; v.btn = b; v.pause = p;
        v.e_dir = d; v.e_step = st; v.e_qc = qc; v.e_full = f; v.e_drop = dr;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic s, input logic [1:0] ld, input logic [3:0] b, input logic p);
        set = s; load_dir = ld; pause = p;
        right_btn = b[0]; left_btn = b[1]; up_btn = b[2]; down_btn = b[3];
    endtask

    task automatic check_outs(input string tag, input logic [3:0] d, input logic st,
                              input logic [2:0] qc, input logic f, input logic dr);
        chk({tag, ".dir"},  {28'd0, out_down, out_up, out_left, out_right}, {28'd0, d});
        chk({tag, ".step"}, {31'd0, step},   {31'd0, st});
        chk({tag, ".qc"},   {29'd0, q_count}, {29'd0, qc});
        chk({tag, ".full"}, {31'd0, q_full}, {31'd0, f});
        chk({tag, ".drop"}, {31'd0, drop},   {31'd0, dr});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int got;
        reset = 1'b1;
        drive(1'b0, 2'b00, 4'b0000, 1'b0);

        // set, ld, btn, pause -> dir, step, qc, full, drop
        add(0, 2'b00, 4'b0100, 0, 4'b0000, 0, 0, 0, 0); // inactive: press ignored
        add(0, 2'b00, 4'b0000, 0, 4'b0000, 0, 0, 0, 0);
        add(1, 2'b00, 4'b1000, 0, 4'b0001, 0, 0, 0, 0); // start right, press ignored
        add(0, 2'b00, 4'b0000, 0, 4'b0001, 0, 0, 0, 0);
        add(0, 2'b00, 4'b0100, 0, 4'b0001, 0, 1, 0, 0); // queue up
        add(0, 2'b00, 4'b0100, 0, 4'b0001, 0, 1, 0, 0); // held, no new press
        add(0, 2'b00, 4'b0110, 0, 4'b0100, 1, 1, 0, 0); // step pops up, pushes left
        add(0, 2'b00, 4'b0000, 0, 4'b0100, 0, 1, 0, 0);
        add(0, 2'b00, 4'b0000, 0, 4'b0100, 0, 1, 0, 0);
        add(0, 2'b00, 4'b0000, 0, 4'b0100, 0, 1, 0, 0);
        add(0, 2'b00, 4'b0000, 0, 4'b0010, 1, 0, 0, 0); // step pops left
        add(0, 2'b00, 4'b0001, 0, 4'b0010, 0, 0, 0, 1); // reversal
        add(0, 2'b00, 4'b0000, 0, 4'b0010, 0, 0, 0, 0);
        add(0, 2'b00, 4'b0010, 0, 4'b0010, 0, 0, 0, 1); // duplicate
        add(0, 2'b00, 4'b0000, 0, 4'b0010, 1, 0, 0, 0); // step, empty queue holds
        add(0, 2'b00, 4'b1101, 0, 4'b0010, 0, 0, 0, 1); // priority picks right: reversal
        add(0, 2'b00, 4'b0000, 1, 4'b0010, 0, 0, 0, 0); // pause x10
        add(0, 2'b00, 4'b1000, 1, 4'b0010, 0, 1, 0, 0);
        add(0, 2'b00, 4'b0000, 1, 4'b0010, 0, 1, 0, 0);
        add(0, 2'b00, 4'b0010, 1, 4'b0010, 0, 2, 0, 0);
        add(0, 2'b00, 4'b0000, 1, 4'b0010, 0, 2, 0, 0);
        add(0, 2'b00, 4'b0100, 1, 4'b0010, 0, 3, 0, 0);
        add(0, 2'b00, 4'b0000, 1, 4'b0010, 0, 3, 0, 0);
        add(0, 2'b00, 4'b0001, 1, 4'b0010, 0, 4, 1, 0); // full
        add(0, 2'b00, 4'b0000, 1, 4'b0010, 0, 4, 1, 0);
        add(0, 2'b00, 4'b0100, 1, 4'b0010, 0, 4, 1, 1); // full, no pop -> drop
        add(0, 2'b00, 4'b0000, 0, 4'b0010, 0, 4, 1, 0); // count resumes at 2
        add(0, 2'b00, 4'b0000, 0, 4'b0010, 0, 4, 1, 0);
        add(0, 2'b00, 4'b1000, 0, 4'b1000, 1, 4, 1, 0); // push on pop edge accepted
        add(0, 2'b00, 4'b0000, 0, 4'b1000, 0, 4, 1, 0);
        add(0, 2'b00, 4'b0000, 0, 4'b1000, 0, 4, 1, 0);
        add(0, 2'b00, 4'b0000, 0, 4'b1000, 0, 4, 1, 0);
        add(0, 2'b00, 4'b0000, 0, 4'b0010, 1, 3, 0, 0); // pops left

        tick();
        tick();
        check_outs("reset", 4'b0000, 0, 0, 0, 0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].set, vecs[i].ld, vecs[i].btn, vecs[i].pause);
            tick();
            $display("vec %0d: dir=%b step=%b qc=%0d full=%b drop=%b", i,
                     {out_down, out_up, out_left, out_right}, step, q_count, q_full, drop);
            check_outs($sformatf("vec%0d", i), vecs[i].e_dir, vecs[i].e_step,
                       vecs[i].e_qc, vecs[i].e_full, vecs[i].e_drop);
        end

        // Asynchronous reset mid-cycle while step is high and three turns are queued.
        drive(1'b0, 2'b00, 4'b0000, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        $display("async reset: dir=%b step=%b qc=%0d", {out_down, out_up, out_left, out_right}, step, q_count);
        check_outs("async_rst", 4'b0000, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 2'b00, (i % 2 == 0) ? 4'b0101 : 4'b0000, 1'b0);
            tick();
            $display("idle %0d: dir=%b qc=%0d drop=%b", i, {out_down, out_up, out_left, out_right}, q_count, drop);
            check_outs($sformatf("idle%0d", i), 4'b0000, 0, 0, 0, 0);
        end

        drive(1'b1, 2'b10, 4'b0000, 1'b0);
        tick();
        $display("set up: dir=%b step=%b", {out_down, out_up, out_left, out_right}, step);
        check_outs("set_up", 4'b0100, 0, 0, 0, 0);
        drive(1'b0, 2'b00, 4'b0000, 1'b0);

        for (int p = 0; p < 2; p++) begin
            got = 0;
            for (int k = 1; k <= 8; k++) begin
                tick();
                if (step) begin
                    got = k;
                    break;
                end
            end
            $display("step period %0d: %0d cycles", p, got);
            chk($sformatf("step_period%0d", p), got, 4);
        end

        drive(1'b0, 2'b00, 4'b0010, 1'b0);
        tick();
        $display("queue left: qc=%0d", q_count);
        check_outs("queue_left", 4'b0100, 0, 1, 0, 0);

        drive(1'b1, 2'b00, 4'b0011, 1'b0);
        tick();
        $display("set flush: dir=%b qc=%0d drop=%b", {out_down, out_up, out_left, out_right}, q_count, drop);
        check_outs("set_flush", 4'b0001, 0, 0, 0, 0);

        drive(1'b0, 2'b00, 4'b0000, 1'b0);
        tick();
        check_outs("after_flush", 4'b0001, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dir_queue_ctrl.md
Name: dir_queue_ctrl

Overview:
Next-generation snake direction controller. It detects button presses on rising edges and rejects reversal and duplicate turns. Accepted turns are buffered in a small FIFO so that fast multi-key input is not lost. One turn is applied per game step, and a divider generates the step pulse. It sits between the debounced direction buttons and the snake body/position logic, which consumes out_* and step.

Parameters:
QDEPTH, 4, pending-turn FIFO depth (>=1)
TICK_DIV, 4, clk cycles per game step (>=2)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
set  input  1  synchronous game start: load direction, flush queue, arm block
load_dir  input  2  direction loaded on set (00 right, 01 left, 10 up, 11 down)
right_btn  input  1  right button level
left_btn  input  1  left button level
up_btn  input  1  up button level
down_btn  input  1  down button level
pause  input  1  freeze step generation while high
out_right  output  1  current direction is right (one-hot group)
out_left  output  1  current direction is left
out_up  output  1  current direction is up
out_down  output  1  current direction is down
step  output  1  one-cycle game-step pulse
q_count  output  $clog2(QDEPTH+1)  pending turns in FIFO
q_full  output  1  FIFO full
drop  output  1  one-cycle pulse: a press was discarded

Behaviour:
- Reset (async, active-high) state:
  - active=0, cur_dir=00, queue empty, tick counter 0.
  - All outputs 0, including out_* (no direction shown before start).
- Reset mid-operation: immediate return to the reset state; the queue is lost.
- While active=0: buttons ignored (no drop), counter halted, step=0.
- set (sync; highest priority after reset):
  - Sets active=1 and cur_dir=load_dir.
  - Flushes the queue and clears the counter.
  - No step and no drop that cycle; a press in the same cycle is ignored.
  - The edge-detect registers still update.
- Press detection:
  - btn_q registers are updated every cycle.
  - press = btn & ~btn_q.
  - Multiple simultaneous presses: priority right > left > up > down. Exactly one candidate is taken; the others are dropped silently (no drop pulse).
- Candidate check:
  - ref = queue tail if q_count>0, else cur_dir.
  - Reject if cand==ref (duplicate) or cand==ref^2'b01 (reversal).
  - Reject if the FIFO is full and no pop occurs this cycle.
  - Any rejection pulses drop for 1 cycle, registered (visible the cycle after the press edge).
- Tick:
  - The counter increments each cycle while active and !pause.
  - At count TICK_DIV-1 the counter wraps to 0, and on that clock edge step<=1 for one cycle.
  - Step period is exactly TICK_DIV cycles.
  - pause holds the count; presses are still queued during pause.
- Pop on step: if q_count>0, head -> cur_dir on the same edge that asserts step, so out_* change coincident with step. If the queue is empty, cur_dir is held.
- Simultaneous push and pop:
  - Both are performed.
  - ref is evaluated before the pop (pre-edge tail).
  - If full, the pop frees a slot and the push is accepted.
  - q_count is unchanged.
- FIFO storage and pointers:
  - Circular buffer; head and tail wrap modulo QDEPTH.
  - q_full = (q_count==QDEPTH).
- out_*: one-hot decode of cur_dir, gated by active. Exactly one output is high while active.

Decomposition:
- Package snake_dir_pkg holds:
  - dir_t 2-bit encodings DIR_RIGHT=00, DIR_LEFT=01, DIR_UP=10, DIR_DOWN=11.
  - Function opposite(d)=d^2'b01.
  - Function dir_onehot(d).
- Sub-module dir_fifo(DEPTH, W=2):
  - Ports: push, pop, din, head, tail, count, full.
  - Same clk/reset convention.
  - Simultaneous push/pop is legal when full.

Test Plan:
- Reset then set with load_dir=10 -> out_up=1 next cycle. step first pulses TICK_DIV=4 cycles after set, then every 4 cycles.
- cur=right, press up then 2 cycles later left -> q_count=2. Next step gives out_up; the following step gives out_left; q_count back to 0.
- cur=right, press left -> drop pulses once, q_count=0. Press right -> drop. Press up -> queued.
- QDEPTH=4: push down,left,up,right alternated validly -> q_full=1. A 5th valid press with no step -> drop. A valid press landing on the step edge -> accepted, q_count stays 4.
- Hold pause 10 cycles -> no step, counter frozen, presses still queue. Release -> step resumes with the remaining count preserved.
- Assert reset with q_count=3 mid-tick -> all outputs 0 immediately, q_count=0. Presses are ignored until set.
